tt_sweep_checker: RTL and testbench
===================================

Name: tt_sweep_checker

Overview:
Sequential stimulus-and-check stage that wraps a 3-input combinational circuit (A, B, C -> F1).
- Upstream side: drives a, b, c through all 8 input combinations, holding each for a programmable settle time.
- Downstream side: samples f1 into a captured 8-bit truth table and compares it against an expected table.
- Reports done, pass, first failing index and mismatch count. Lets the combinational lab circuit be exhaustively checked in hardware without a simulator bench.

Parameters:
SETTLE_CYCLES, 2, cycles each input vector is held before f1 is sampled; legal range 1..255 (0 illegal).

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle request to begin a sweep; honoured only in IDLE or DONE
exp_tt  input  8  expected truth table; bit i = expected F1 for {A,B,C}=i; latched when start is accepted
f1  input  1  output of circuit under check
a  output  1  stimulus MSB (idx[2])
b  output  1  stimulus idx[1]
c  output  1  stimulus LSB (idx[0])
busy  output  1  high while a sweep is in progress (SETTLE or SAMPLE)
done  output  1  level; high in DONE until next accepted start or reset
pass  output  1  done && err_count==0
tt  output  8  captured truth table; bit i = sampled f1 for idx i
err_count  output  4  number of mismatching indices, 0..8
fail_idx  output  3  index of first mismatch; 0 when none

Behaviour:
- Reset (async, active-high) forces:
  - state=IDLE; idx=0; cnt=0
  - a=b=c=0; busy=0; done=0; pass=0
  - tt=8'h00; err_count=0; fail_idx=0; latched expected=8'h00
  - Reset mid-sweep aborts immediately; no partial result survives.
- State machine states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE / DONE with start=1 at an edge:
  - latch exp_tt; idx=0; cnt=0
  - clear tt, err_count, fail_idx and the first-fail flag
  - done=0; go to SETTLE
- SETTLE:
  - {a,b,c}=idx continuously.
  - If cnt==SETTLE_CYCLES-1: cnt=0, go to SAMPLE; else cnt++.
  - Occupies exactly SETTLE_CYCLES cycles.
- SAMPLE (1 cycle), {a,b,c} still = idx. At the edge:
  - tt[idx] <= f1.
  - If f1 != exp[idx]: err_count++. If this is the first mismatch, fail_idx <= idx and the first-fail flag is set.
  - If idx==7: go to DONE. Otherwise idx++ and go to SETTLE.
- DONE:
  - done=1; busy=0; {a,b,c} hold 3'b111.
  - tt, err_count and fail_idx are stable.
- Outputs are registered (a/b/c derive from registered idx); no combinational path from f1 to any output.
- Latency: start accepted at edge k -> done high after edge k + 8*(SETTLE_CYCLES+1). Default: 24 cycles.
- start while busy: ignored; does not restart or re-latch exp_tt.
- Changes on exp_tt after acceptance: ignored.
- f1 is sampled only in SAMPLE; glitches during SETTLE have no effect.
- err_count saturation is not needed (max 8 fits in 4 bits).
- cnt is 8 bits wide.

Test Plan:
1. Model f1=(a&b)|c, exp_tt=8'hEA, pulse start -> done rises exactly 24 cycles after the accepting edge; tt=8'hEA, err_count=0, fail_idx=0, pass=1; a,b,c step 000..111, each held 3 cycles.
2. Same model, exp_tt=8'hE8 -> tt=8'hEA, err_count=1, fail_idx=1, pass=0.
3. Model f1=0, exp_tt=8'hFF -> err_count=8, fail_idx=0, tt=8'h00, pass=0.
4. Assert reset during SETTLE of idx=4 -> all outputs return to reset values asynchronously (before next edge); new start then yields a full correct sweep.
5. Pulse start again at cycle 10 of a running sweep, with exp_tt changed to 8'h00 -> ignored; result identical to scenario 1.
6. SETTLE_CYCLES=1, scenario 1 stimulus -> done after 16 cycles, pass=1. Then start from DONE with exp_tt=8'h00 -> done drops the next cycle, err_count=5, fail_idx=1.

Source files
------------

// File: rtl/tt_sweep_checker.sv
// Exhaustive truth-table checker for a 3-input combinational circuit: steps {a,b,c}
// through 0..7, samples f1 after a settle delay and compares it with a latched expected table.
module tt_sweep_checker #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] exp_tt,
  input  logic       f1,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] tt,
  output logic [3:0] err_count,
  output logic [2:0] fail_idx
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] exp_q, exp_d;
  logic [7:0] tt_q, tt_d;
  logic [3:0] err_q, err_d;
  logic [2:0] fail_q, fail_d;
  logic       first_q, first_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    tt_d    = tt_q;
    err_d   = err_q;
    fail_d  = fail_q;
    first_d = first_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          exp_d   = exp_tt;
          idx_d   = '0;
          cnt_d   = '0;
          tt_d    = '0;
          err_d   = '0;
          fail_d  = '0;
          first_d = 1'b0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_SAMPLE: begin
        tt_d[idx_q] = f1;
        if (f1 != exp_q[idx_q]) begin
          err_d = err_q + 4'd1;
          if (!first_q) begin
            fail_d  = idx_q;
            first_d = 1'b1;
          end
        end
        // idx stays at 7 on completion so {a,b,c} rests at 3'b111 in DONE
        if (idx_q == 3'd7) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == 4'd0);
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = S_SETTLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      tt_q    <= '0;
      err_q   <= '0;
      fail_q  <= '0;
      first_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      tt_q    <= tt_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      first_q <= first_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign a         = idx_q[2];
  assign b         = idx_q[1];
  assign c         = idx_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign tt        = tt_q;
  assign err_count = err_q;
  assign fail_idx  = fail_q;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Bench for tt_sweep_checker: two instances (settle 2 and settle 1) driven from a vector
// table, with expected sweep results queued at start and compared when done rises.
module tb_tt_sweep_checker;

  logic       clk = 1'b0;
  logic       reset, start, sel;
  logic [1:0] mode;
  logic [7:0] exp_tt;

  logic start0, start1, f1_0, f1_1;
  logic a0, b0, c0, busy0, done0, pass0;
  logic a1, b1, c1, busy1, done1, pass1;
  logic [7:0] tt0, tt1;
  logic [3:0] err0, err1;
  logic [2:0] fail0, fail1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic model(input logic [1:0] m, input logic x, input logic y, input logic z);
    case (m)
      2'd0:    model = (x & y) | z;
      2'd1:    model = 1'b0;
      default: model = ~((x & y) | z);
    endcase
  endfunction

  assign start0 = start & ~sel;
  assign start1 = start & sel;
  assign f1_0   = model(mode, a0, b0, c0);
  assign f1_1   = model(mode, a1, b1, c1);

  tt_sweep_checker #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .start(start0), .exp_tt(exp_tt), .f1(f1_0),
    .a(a0), .b(b0), .c(c0), .busy(busy0), .done(done0), .pass(pass0),
    .tt(tt0), .err_count(err0), .fail_idx(fail0)
  );

  tt_sweep_checker #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .exp_tt(exp_tt), .f1(f1_1),
    .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1), .pass(pass1),
    .tt(tt1), .err_count(err1), .fail_idx(fail1)
  );

  logic [2:0] o_abc, o_fail;
  logic       o_busy, o_done, o_pass;
  logic [7:0] o_tt;
  logic [3:0] o_err;
  assign o_abc  = sel ? {a1, b1, c1} : {a0, b0, c0};
  assign o_busy = sel ? busy1 : busy0;
  assign o_done = sel ? done1 : done0;
  assign o_pass = sel ? pass1 : pass0;
  assign o_tt   = sel ? tt1 : tt0;
  assign o_err  = sel ? err1 : err0;
  assign o_fail = sel ? fail1 : fail0;

  typedef struct {
    logic       sel;
    logic [1:0] mode;
    logic [7:0] exp_in;
    int         restart_at;
    logic [7:0] tt;
    logic [3:0] err;
    logic [2:0] fail;
    logic       pass;
  } vec_t;

  typedef struct {
    logic [7:0] tt;
    logic [3:0] err;
    logic [2:0] fail;
    logic       pass;
    int         lat;
  } res_t;

  res_t sb[$];
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_abc0", 32'({a0, b0, c0}), 0);
    chk("rst_busy0", 32'(busy0), 0);
    chk("rst_done0", 32'(done0), 0);
    chk("rst_pass0", 32'(pass0), 0);
    chk("rst_tt0", 32'(tt0), 0);
    chk("rst_err0", 32'(err0), 0);
    chk("rst_fail0", 32'(fail0), 0);
    chk("rst_done1", 32'(done1), 0);
    chk("rst_tt1", 32'(tt1), 0);
    chk("rst_abc1", 32'({a1, b1, c1}), 0);
  endtask

  task automatic run_vec(input vec_t v);
    int   s;
    int   n;
    res_t r;
    sel  = v.sel;
    mode = v.mode;
    s    = v.sel ? 1 : 2;
    @(negedge clk);
    exp_tt = v.exp_in;
    start  = 1'b1;
    r.tt = v.tt; r.err = v.err; r.fail = v.fail; r.pass = v.pass; r.lat = 8 * (s + 1);
    sb.push_back(r);
    @(negedge clk);
    start  = 1'b0;
    exp_tt = ~v.exp_in;
    chk("done_drop", 32'(o_done), 0);
    n = 1;
    while (n <= 200 && !o_done) begin
      chk("abc_step", 32'(o_abc), 32'(((n - 1) / (s + 1)) % 8));
      chk("busy", 32'(o_busy), 1);
      if (n == v.restart_at) begin
        start  = 1'b1;
        exp_tt = 8'h00;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("done_seen", 32'(o_done), 1);
    if (sb.size() == 0) begin
      chk("sb_empty", 0, 1);
    end else begin
      r = sb.pop_front();
      chk("latency", 32'(n - 1), 32'(r.lat));
      chk("tt", 32'(o_tt), 32'(r.tt));
      chk("err_count", 32'(o_err), 32'(r.err));
      chk("fail_idx", 32'(o_fail), 32'(r.fail));
      chk("pass", 32'(o_pass), 32'(r.pass));
    end
    chk("busy_done", 32'(o_busy), 0);
    chk("abc_done", 32'(o_abc), 7);
    @(negedge clk);
    chk("done_hold", 32'(o_done), 1);
  endtask

  task automatic abort_seq();
    sel  = 1'b0;
    mode = 2'd0;
    @(negedge clk);
    exp_tt = 8'hEA;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n < 13; n++) @(negedge clk);
    chk("abort_idx4", 32'({a0, b0, c0}), 4);
    reset = 1'b1;
    #1;
    chk_reset_vals();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 2'd0, 8'hEA, 0,  8'hEA, 4'd0, 3'd0, 1'b1};
    vecs[1] = '{1'b0, 2'd0, 8'hE8, 0,  8'hEA, 4'd1, 3'd1, 1'b0};
    vecs[2] = '{1'b0, 2'd1, 8'hFF, 0,  8'h00, 4'd8, 3'd0, 1'b0};
    vecs[3] = '{1'b0, 2'd0, 8'hEA, 10, 8'hEA, 4'd0, 3'd0, 1'b1};
    vecs[4] = '{1'b0, 2'd2, 8'h15, 0,  8'h15, 4'd0, 3'd0, 1'b1};
    vecs[5] = '{1'b0, 2'd1, 8'h00, 0,  8'h00, 4'd0, 3'd0, 1'b1};
    vecs[6] = '{1'b1, 2'd0, 8'hEA, 0,  8'hEA, 4'd0, 3'd0, 1'b1};
    vecs[7] = '{1'b1, 2'd0, 8'h00, 0,  8'hEA, 4'd5, 3'd1, 1'b0};

    reset  = 1'b1;
    start  = 1'b0;
    sel    = 1'b0;
    mode   = 2'd0;
    exp_tt = 8'h00;
    repeat (2) @(negedge clk);
    chk_reset_vals();
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);
    abort_seq();
    run_vec(vecs[0]);
    for (int i = 6; i < 8; i++) run_vec(vecs[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
